// File: rtl/shift_operand_unit_pkg.sv
// Shared types for the shift operand unit.
//   shift_type_t : shifter type as encoded in shifter_operand[6:5]
package shift_operand_unit_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_t;

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational barrel shifter with carry-out for an already-resolved shift.
// Ports:
//   src      value to shift
//   sh_type  LSL/LSR/ASR/ROR
//   amt      resolved amount, 0..DATA_W (ROR: DATA_W means "full turn")
//   over     amount was larger than DATA_W (LSL/LSR give 0/0, ASR saturates)
//   rrx      rotate right by one through carry, overrides amt
//   cin      carry used when nothing is shifted, and as RRX fill bit
//   val/cout shifted value and carry-out
module barrel_shift_core
    import shift_operand_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DATA_W) + 1
) (
    input  logic [DATA_W-1:0] src,
    input  shift_type_t       sh_type,
    input  logic [AW-1:0]     amt,
    input  logic              over,
    input  logic              rrx,
    input  logic              cin,
    output logic [DATA_W-1:0] val,
    output logic              cout
);

    localparam logic [AW-1:0] W_AMT = AW'(DATA_W);

    // One extra bit on the shifted-out side captures the carry directly.
    logic [DATA_W:0]        lsl_ext;
    logic [DATA_W:0]        lsr_ext;
    logic signed [DATA_W:0] asr_ext;
    logic [AW-2:0]          rot;
    logic [DATA_W-1:0]      ror_val;

    always_comb begin
        lsl_ext = {1'b0, src} << amt;
        lsr_ext = {src, 1'b0} >> amt;
        asr_ext = $signed({src, 1'b0}) >>> amt;
        // amt == DATA_W folds to a zero rotation; carry still comes from the MSB.
        rot     = amt[AW-2:0];
        ror_val = (src >> rot) | (src << (DATA_W - int'(rot)));

        val  = src;
        cout = cin;
        if (rrx) begin
            val  = {cin, src[DATA_W-1:1]};
            cout = src[0];
        end else if (amt != '0 || over) begin
            case (sh_type)
                SH_LSL: begin
                    val  = over ? '0 : lsl_ext[DATA_W-1:0];
                    cout = over ? 1'b0 : lsl_ext[DATA_W];
                end
                SH_LSR: begin
                    val  = over ? '0 : lsr_ext[DATA_W:1];
                    cout = over ? 1'b0 : lsr_ext[0];
                end
                SH_ASR: begin
                    if (over || amt >= W_AMT) begin
                        val  = {DATA_W{src[DATA_W-1]}};
                        cout = src[DATA_W-1];
                    end else begin
                        val  = asr_ext[DATA_W:1];
                        cout = asr_ext[0];
                    end
                end
                SH_ROR: begin
                    val  = ror_val;
                    cout = ror_val[DATA_W-1];
                end
                default: begin
                    val  = src;
                    cout = cin;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_operand_unit.sv
// Pipelined second-operand generator for the EXE stage.
// Decodes the shifter operand (memory offset, rotated immediate, shift by
// immediate, shift by Rs) into a resolved shift, runs it through the barrel
// core and returns val2 plus shifter carry-out with valid/ready on both sides.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      kill all in-flight entries (and this cycle's input)
//   in_valid/in_ready          input handshake
//   in_imm, in_mem             operand mode (in_mem wins over in_imm)
//   in_shift_op                shifter_operand[11:0]
//   in_rm, in_rs, in_carry     Rm, Rs and current C flag
//   in_tag                     sideband tag, returned with the result
//   out_valid/out_ready        output handshake
//   out_val2, out_carry        generated operand and carry-out
//   out_tag                    tag of the result
module shift_operand_unit
    import shift_operand_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_imm,
    input  logic              in_mem,
    input  logic [11:0]       in_shift_op,
    input  logic [DATA_W-1:0] in_rm,
    input  logic [DATA_W-1:0] in_rs,
    input  logic              in_carry,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_val2,
    output logic              out_carry,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int AW = $clog2(DATA_W) + 1;

    // Only Rs[7:0] is a shift amount.
    logic unused_rs;
    assign unused_rs = ^in_rs[DATA_W-1:8];

    int                raw_amt;
    logic [DATA_W-1:0] r_src;
    shift_type_t       r_type;
    logic [AW-1:0]     r_amt;
    logic              r_over;
    logic              r_rrx;

    // Resolve every mode into (src, type, amount, over, rrx).
    always_comb begin
        raw_amt = in_shift_op[4] ? int'(in_rs[7:0]) : int'(in_shift_op[11:7]);
        r_src   = in_rm;
        r_type  = shift_type_t'(in_shift_op[6:5]);
        r_amt   = '0;
        r_over  = 1'b0;
        r_rrx   = 1'b0;
        if (in_mem) begin
            r_src  = DATA_W'(in_shift_op);
            r_type = SH_LSL;
        end else if (in_imm) begin
            r_src  = DATA_W'(in_shift_op[7:0]);
            r_type = SH_ROR;
            r_amt  = AW'((2 * int'(in_shift_op[11:8])) % DATA_W);
        end else if (!in_shift_op[4] && raw_amt == 0) begin
            // Immediate #0: LSL is a pass-through, LSR/ASR mean #DATA_W, ROR is RRX.
            if (r_type == SH_ROR) begin
                r_rrx = 1'b1;
            end else if (r_type != SH_LSL) begin
                r_amt = AW'(DATA_W);
            end
        end else if (r_type == SH_ROR) begin
            // Non-zero multiples of DATA_W keep rm but take carry from the MSB.
            if (raw_amt != 0) begin
                r_amt = (raw_amt % DATA_W == 0) ? AW'(DATA_W) : AW'(raw_amt % DATA_W);
            end
        end else if (raw_amt > DATA_W) begin
            r_amt  = AW'(DATA_W);
            r_over = 1'b1;
        end else begin
            r_amt = AW'(raw_amt);
        end
    end

    logic              out_adv;
    logic              core_valid;
    logic [DATA_W-1:0] core_val;
    logic              core_cout;
    logic [TAG_W-1:0]  core_tag;

    assign out_adv = !out_valid || out_ready;

    generate
        if (LATENCY == 2) begin : g_two_stage
            logic              s1_valid;
            logic              s1_adv;
            logic [DATA_W-1:0] s1_src;
            shift_type_t       s1_type;
            logic [AW-1:0]     s1_amt;
            logic              s1_over;
            logic              s1_rrx;
            logic              s1_cin;
            logic [TAG_W-1:0]  s1_tag;

            assign s1_adv   = !s1_valid || out_adv;
            assign in_ready = s1_adv;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                    s1_src   <= '0;
                    s1_type  <= SH_LSL;
                    s1_amt   <= '0;
                    s1_over  <= 1'b0;
                    s1_rrx   <= 1'b0;
                    s1_cin   <= 1'b0;
                    s1_tag   <= '0;
                end else if (flush) begin
                    s1_valid <= 1'b0;
                end else if (s1_adv) begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1_src  <= r_src;
                        s1_type <= r_type;
                        s1_amt  <= r_amt;
                        s1_over <= r_over;
                        s1_rrx  <= r_rrx;
                        s1_cin  <= in_carry;
                        s1_tag  <= in_tag;
                    end
                end
            end

            barrel_shift_core #(.DATA_W(DATA_W)) u_core (
                .src     (s1_src),
                .sh_type (s1_type),
                .amt     (s1_amt),
                .over    (s1_over),
                .rrx     (s1_rrx),
                .cin     (s1_cin),
                .val     (core_val),
                .cout    (core_cout)
            );

            assign core_valid = s1_valid;
            assign core_tag   = s1_tag;
        end else begin : g_one_stage
            assign in_ready = out_adv;

            barrel_shift_core #(.DATA_W(DATA_W)) u_core (
                .src     (r_src),
                .sh_type (r_type),
                .amt     (r_amt),
                .over    (r_over),
                .rrx     (r_rrx),
                .cin     (in_carry),
                .val     (core_val),
                .cout    (core_cout)
            );

            assign core_valid = in_valid;
            assign core_tag   = in_tag;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_val2  <= '0;
            out_carry <= 1'b0;
            out_tag   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (out_adv) begin
            out_valid <= core_valid;
            if (core_valid) begin
                out_val2  <= core_val;
                out_carry <= core_cout;
                out_tag   <= core_tag;
            end
        end
    end

endmodule

// File: tb/tb_shift_operand_unit.sv
module tb_shift_operand_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_imm = 1'b0;
    logic        in_mem = 1'b0;
    logic [11:0] in_shift_op = '0;
    logic [31:0] in_rm = '0;
    logic [31:0] in_rs = '0;
    logic        in_carry = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_val2;
    logic        out_carry;
    logic [3:0]  out_tag;

    int checks = 0;
    int errors = 0;

    logic [36:0] sb_q[$];

    shift_operand_unit #(.DATA_W(32), .LATENCY(2), .TAG_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_imm      (in_imm),
        .in_mem      (in_mem),
        .in_shift_op (in_shift_op),
        .in_rm       (in_rm),
        .in_rs       (in_rs),
        .in_carry    (in_carry),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_val2    (out_val2),
        .out_carry   (out_carry),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    // Reference: shift one bit at a time, remembering the last bit that fell off.
    function automatic logic [32:0] model(input logic imm, input logic mem,
                                          input logic [11:0] op, input logic [31:0] rm,
                                          input logic [31:0] rs, input logic cin);
        logic [31:0] v;
        logic        c;
        int          n;
        logic [1:0]  t;
        v = rm;
        c = cin;
        if (mem) begin
            v = {20'b0, op};
        end else if (imm) begin
            v = {24'b0, op[7:0]};
            n = 2 * int'(op[11:8]);
            for (int i = 0; i < n; i++) begin
                c = v[0];
                v = {v[0], v[31:1]};
            end
            if (n == 0) c = cin;
        end else begin
            t = op[6:5];
            n = op[4] ? int'(rs[7:0]) : int'(op[11:7]);
            if (!op[4] && n == 0 && t == 2'b11) begin
                v = {cin, rm[31:1]};
                c = rm[0];
            end else begin
                if (!op[4] && n == 0 && (t == 2'b01 || t == 2'b10)) n = 32;
                for (int i = 0; i < n; i++) begin
                    case (t)
                        2'b00:   begin c = v[31]; v = v << 1; end
                        2'b01:   begin c = v[0];  v = v >> 1; end
                        2'b10:   begin c = v[0];  v = {v[31], v[31:1]}; end
                        default: begin c = v[0];  v = {v[0], v[31:1]}; end
                    endcase
                end
            end
        end
        return {v, c};
    endfunction

    // Scoreboard: record accepted operands, check every delivery in order.
    always @(negedge clk) begin
        logic [36:0] exp_e;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                assert (sb_q.size() > 0) else begin
                    errors++;
                    $error("FAIL sb_unexpected observed tag %0d val %h expected no output", out_tag, out_val2);
                end
                if (sb_q.size() > 0) begin
                    exp_e = sb_q.pop_front();
                    checks++;
                    assert ({out_val2, out_carry, out_tag} === exp_e) else begin
                        errors++;
                        $error("FAIL sb_data observed val %h c %b tag %0d expected val %h c %b tag %0d",
                               out_val2, out_carry, out_tag, exp_e[36:5], exp_e[4], exp_e[3:0]);
                    end
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready)
                sb_q.push_back({model(in_imm, in_mem, in_shift_op, in_rm, in_rs, in_carry), in_tag});
        end
    end

    task automatic send(input logic imm, input logic mem, input logic [11:0] op,
                        input logic [31:0] rm, input logic [31:0] rs,
                        input logic cin, input logic [3:0] tag);
        int k;
        in_imm = imm; in_mem = mem; in_shift_op = op;
        in_rm = rm; in_rs = rs; in_carry = cin; in_tag = tag;
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        assert (in_ready === 1'b1) else begin
            errors++;
            $error("FAIL send_timeout observed in_ready %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] ev, input logic ec);
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        assert (out_valid === 1'b1) else begin
            errors++;
            $error("FAIL %s_valid observed %b expected 1", name, out_valid);
        end
        checks++;
        assert (out_val2 === ev) else begin
            errors++;
            $error("FAIL %s_val observed %h expected %h", name, out_val2, ev);
        end
        checks++;
        assert (out_carry === ec) else begin
            errors++;
            $error("FAIL %s_carry observed %b expected %b", name, out_carry, ec);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_bit(input string name, input logic obs, input logic exp_b);
        checks++;
        assert (obs === exp_b) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", name, obs, exp_b);
        end
    endtask

    initial begin
        logic [7:0] amt8;
        // ---- reset ----
        #22 rst_n = 1'b1;
        @(negedge clk);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_out_carry", out_carry, 1'b0);
        checks++;
        assert ({out_val2, out_tag} === 36'h0) else begin
            errors++;
            $error("FAIL rst_val_tag observed %h/%0d expected 0/0", out_val2, out_tag);
        end
        @(posedge clk); #1;

        // ---- directed operand cases ----
        out_ready = 1'b1;
        send(1'b1, 1'b0, 12'h4FF, 32'h0, 32'h0, 1'b0, 4'd1);
        expect_out("imm_rot", 32'hFF000000, 1'b1);
        send(1'b0, 1'b0, 12'h020, 32'h80000001, 32'h0, 1'b0, 4'd2);
        expect_out("lsr0", 32'h0, 1'b1);
        send(1'b0, 1'b0, 12'h060, 32'h3, 32'h0, 1'b1, 4'd3);
        expect_out("rrx", 32'h80000001, 1'b1);
        send(1'b0, 1'b0, 12'h010, 32'hFFFFFFFF, 32'd32, 1'b0, 4'd4);
        expect_out("reg_lsl32", 32'h0, 1'b1);
        send(1'b0, 1'b0, 12'h010, 32'hFFFFFFFF, 32'd33, 1'b1, 4'd5);
        expect_out("reg_lsl33", 32'h0, 1'b0);
        send(1'b0, 1'b0, 12'h010, 32'hFFFFFFFF, 32'd0, 1'b1, 4'd6);
        expect_out("reg_lsl0", 32'hFFFFFFFF, 1'b1);
        send(1'b1, 1'b1, 12'hABC, 32'h12345678, 32'h0, 1'b1, 4'd7);
        expect_out("mem", 32'h00000ABC, 1'b1);
        send(1'b0, 1'b0, 12'h040, 32'h80000000, 32'h0, 1'b0, 4'd8);
        expect_out("asr0", 32'hFFFFFFFF, 1'b1);
        send(1'b0, 1'b0, 12'h070, 32'h80000001, 32'd64, 1'b0, 4'd9);
        expect_out("reg_ror64", 32'h80000001, 1'b1);

        // ---- backpressure: two accepted, third held, in-order drain ----
        out_ready = 1'b0;
        send(1'b0, 1'b0, 12'h000, 32'h11, 32'h0, 1'b0, 4'd1);
        send(1'b0, 1'b0, 12'h000, 32'h22, 32'h0, 1'b0, 4'd2);
        in_rm = 32'h33; in_tag = 4'd3; in_valid = 1'b1;
        @(negedge clk);
        check_bit("bp_in_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        assert (out_valid === 1'b1 && out_tag === 4'd1) else begin
            errors++; $error("FAIL bp_tag1 observed v %b tag %0d expected v 1 tag 1", out_valid, out_tag);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int t = 2; t <= 3; t++) begin
            @(negedge clk);
            checks++;
            assert (out_valid === 1'b1 && out_tag === 4'(t)) else begin
                errors++; $error("FAIL bp_tag%0d observed v %b tag %0d expected v 1 tag %0d", t, out_valid, out_tag, t);
            end
        end
        @(negedge clk);
        check_bit("bp_drained", out_valid, 1'b0);
        @(posedge clk); #1;

        // ---- flush with two in flight ----
        out_ready = 1'b0;
        send(1'b0, 1'b0, 12'h000, 32'h44, 32'h0, 1'b0, 4'd4);
        send(1'b0, 1'b0, 12'h000, 32'h55, 32'h0, 1'b0, 4'd5);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check_bit("flush_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_bit("flush_no_leak", out_valid, 1'b0);

        // ---- flush beats a simultaneous accept ----
        in_rm = 32'h66; in_tag = 4'd6; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("flush_drop_input", out_valid, 1'b0);
        @(posedge clk); #1;

        // ---- async reset with a result waiting ----
        out_ready = 1'b0;
        send(1'b0, 1'b0, 12'h000, 32'h77, 32'h0, 1'b0, 4'd7);
        @(negedge clk);
        @(negedge clk);
        check_bit("arst_pre_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_bit("arst_out_valid", out_valid, 1'b0);
        checks++;
        assert (out_val2 === 32'h0) else begin
            errors++; $error("FAIL arst_val observed %h expected 0", out_val2);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- randomized traffic against the reference model ----
        for (int i = 0; i < 600; i++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            out_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 49) == 0);
            in_mem      = ($urandom_range(0, 9) == 0);
            in_imm      = ($urandom_range(0, 4) == 0);
            in_shift_op = 12'($urandom);
            in_rm       = $urandom;
            in_carry    = 1'($urandom);
            in_tag      = 4'($urandom);
            case ($urandom_range(0, 5))
                0: amt8 = 8'd0;
                1: amt8 = 8'd32;
                2: amt8 = 8'd33;
                3: amt8 = 8'd31;
                4: amt8 = 8'd64;
                default: amt8 = 8'($urandom);
            endcase
            in_rs = {24'($urandom), amt8};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        assert (sb_q.size() == 0) else begin
            errors++; $error("FAIL drain_left observed %0d pending expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
